// File: rtl/ariane_regfile_sb_if.sv
// Bus bundle for ariane_regfile_sb: read ports, allocation handshake, write-back ports, busy vector.
interface ariane_regfile_sb_if #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_WORDS      = 32,
  parameter int unsigned NR_READ_PORTS  = 2,
  parameter int unsigned NR_WRITE_PORTS = 2
);
  localparam int unsigned AW = $clog2(NUM_WORDS);

  logic [NR_READ_PORTS*AW-1:0]          raddr_i;
  logic [NR_READ_PORTS*DATA_WIDTH-1:0]  rdata_o;
  logic [NR_READ_PORTS-1:0]             rready_o;
  logic                                 alloc_valid_i;
  logic [AW-1:0]                        alloc_addr_i;
  logic                                 alloc_ready_o;
  logic [NR_WRITE_PORTS*AW-1:0]         waddr_i;
  logic [NR_WRITE_PORTS*DATA_WIDTH-1:0] wdata_i;
  logic [NR_WRITE_PORTS-1:0]            we_i;
  logic [NUM_WORDS-1:0]                 busy_o;

  modport slave (
    input  raddr_i, alloc_valid_i, alloc_addr_i, waddr_i, wdata_i, we_i,
    output rdata_o, rready_o, alloc_ready_o, busy_o
  );

  modport master (
    output raddr_i, alloc_valid_i, alloc_addr_i, waddr_i, wdata_i, we_i,
    input  rdata_o, rready_o, alloc_ready_o, busy_o
  );
endinterface

// File: rtl/ariane_regfile_sb.sv
// Multi-port register file with integrated busy scoreboard and prioritised write-back ports.
// Optional write-to-read forwarding is enabled by defining REGFILE_FWD_EN.
module ariane_regfile_sb #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_WORDS      = 32,
  parameter int unsigned NR_READ_PORTS  = 2,
  parameter int unsigned NR_WRITE_PORTS = 2,
  parameter bit          ZERO_REG_ZERO  = 1'b1
) (
  input logic                clk_i,
  input logic                rst_i,
  ariane_regfile_sb_if.slave bus
);
  localparam int unsigned AW = $clog2(NUM_WORDS);

  logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
  logic [DATA_WIDTH-1:0] mem_d [NUM_WORDS];
  logic [NUM_WORDS-1:0]  busy_q;
  logic [NUM_WORDS-1:0]  busy_d;

  logic [AW-1:0]         waddr_a [NR_WRITE_PORTS];
  logic [DATA_WIDTH-1:0] wdata_a [NR_WRITE_PORTS];
  logic [AW-1:0]         raddr_a [NR_READ_PORTS];
  logic                  alloc_ready;

  always_comb begin
    for (int unsigned w = 0; w < NR_WRITE_PORTS; w++) begin
      waddr_a[w] = bus.waddr_i[w*AW +: AW];
      wdata_a[w] = bus.wdata_i[w*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int unsigned r = 0; r < NR_READ_PORTS; r++) begin
      raddr_a[r] = bus.raddr_i[r*AW +: AW];
    end
  end

  // Only registered busy feeds the accept decision, so there is no path from we_i.
  assign alloc_ready       = bus.alloc_valid_i & ~busy_q[bus.alloc_addr_i];
  assign bus.alloc_ready_o = alloc_ready;
  assign bus.busy_o        = busy_q;

  always_comb begin
    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
      mem_d[i] = mem_q[i];
    end
    busy_d = busy_q;
    // Ascending port order lets the highest-indexed port overwrite earlier ones.
    for (int unsigned w = 0; w < NR_WRITE_PORTS; w++) begin
      if (bus.we_i[w] && !(ZERO_REG_ZERO && waddr_a[w] == '0)) begin
        mem_d[waddr_a[w]]  = wdata_a[w];
        busy_d[waddr_a[w]] = 1'b0;
      end
    end
    // Allocation is newer than any write-back in flight, so it is applied last.
    if (alloc_ready && !(ZERO_REG_ZERO && bus.alloc_addr_i == '0)) begin
      busy_d[bus.alloc_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
        mem_q[i] <= mem_d[i];
      end
      busy_q <= busy_d;
    end
  end

  always_comb begin
    bus.rdata_o  = '0;
    bus.rready_o = '0;
    for (int unsigned r = 0; r < NR_READ_PORTS; r++) begin
      bus.rdata_o[r*DATA_WIDTH +: DATA_WIDTH] = mem_q[raddr_a[r]];
      bus.rready_o[r]                         = ~busy_q[raddr_a[r]];
`ifdef REGFILE_FWD_EN
      for (int unsigned w = 0; w < NR_WRITE_PORTS; w++) begin
        if (bus.we_i[w] && waddr_a[w] == raddr_a[r]) begin
          bus.rdata_o[r*DATA_WIDTH +: DATA_WIDTH] = wdata_a[w];
          bus.rready_o[r]                         = 1'b1;
        end
      end
`endif
      if (ZERO_REG_ZERO && raddr_a[r] == '0) begin
        bus.rdata_o[r*DATA_WIDTH +: DATA_WIDTH] = '0;
        bus.rready_o[r]                         = 1'b1;
      end
    end
  end
endmodule
